// File: rtl/sfp_dft_engine.sv
`default_nettype none
// ============================================================================
// Module   : sfp_dft_engine
// Purpose  : 4-point DFT (radix-4) or dual 2-point butterfly (radix-2) on
//            small-floating-point (SFP) complex samples, using a block
//            exponent and a fixed-point sum datapath.
// Ports    : clk        - clock
//            rst        - asynchronous active-low reset
//            in_valid   - input frame valid
//            in_ready   - frame accepted when in_valid && in_ready
//            mode       - [1] radix-4 (1) / dual radix-2 (0), [0] inverse
//            in_real/in_imag   - 4 SFP lanes each, lane k at [SFP_W*k +: SFP_W]
//            out_valid  - result valid
//            out_ready  - consumer ready
//            out_real/out_imag - 4 SFP lanes each, lane k = X_k
//            frame_cnt  - frames delivered (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module sfp_dft_engine #(
  parameter int EXP_W      = 4,
  parameter int SIG_W      = 4,
  parameter int LOW_EXPAND = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       mode,
  input  logic [4*(1+EXP_W+SIG_W)-1:0]     in_real,
  input  logic [4*(1+EXP_W+SIG_W)-1:0]     in_imag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [4*(1+EXP_W+SIG_W)-1:0]     out_real,
  output logic [4*(1+EXP_W+SIG_W)-1:0]     out_imag,
  output logic [15:0]                      frame_cnt
);

  localparam int SFP_W = 1 + EXP_W + SIG_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  // Largest encodable biased exponent (all ones).
  localparam int EMAX  = 2 * BIAS + 1;
  // Fixed-point word: sign + 2 growth bits + hidden bit + fraction + guards.
  localparam int FW    = SIG_W + 4 + LOW_EXPAND;
  // Significant magnitude bits of one aligned operand.
  localparam int MW    = SIG_W + 1 + LOW_EXPAND;
  // Bit position of the hidden one in an unshifted operand.
  localparam int HB    = SIG_W + LOW_EXPAND;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [EXP_W-1:0] f_exp(input logic [SFP_W-1:0] x);
    return x[SFP_W-2 -: EXP_W];
  endfunction

  function automatic logic [EXP_W-1:0] f_max(input logic [EXP_W-1:0] a,
                                             input logic [EXP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Convert one SFP value to signed fixed point relative to block exponent be.
  function automatic logic signed [FW-1:0] f_align(input logic [SFP_W-1:0] x,
                                                   input logic [EXP_W-1:0] be);
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] sh;
    logic [FW-1:0]    mag;
    e  = x[SFP_W-2 -: EXP_W];
    sh = be - e;
    if (e == '0 || int'(sh) >= MW) begin
      return '0;
    end
    mag = (FW'({1'b1, x[SIG_W-1:0]}) << LOW_EXPAND) >> sh;
    return x[SFP_W-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Renormalise a fixed-point sum back to SFP with flush and saturation.
  function automatic logic [SFP_W-1:0] f_renorm(input logic signed [FW-1:0] sum,
                                                input logic [EXP_W-1:0]     be);
    logic          s;
    logic [FW-1:0] mag;
    logic [FW-1:0] norm;
    int            p;
    int            e;
    s   = sum[FW-1];
    mag = s ? -sum : sum;
    p   = -1;
    for (int i = 0; i < FW; i++) begin
      if (mag[i]) p = i;
    end
    if (p < 0) begin
      return '0;
    end
    e    = int'(be) + p - HB;
    // Put the leading one at the MSB; the fraction is the bits right below it.
    norm = mag << (FW - 1 - p);
    if (e <= 0) begin
      return '0;
    end else if (e > EMAX) begin
      return {s, {EXP_W{1'b1}}, {SIG_W{1'b1}}};
    end
    return {s, e[EXP_W-1:0], norm[FW-2 -: SIG_W]};
  endfunction

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_adv;
  logic r_v1, r_v2, r_v3, r_v4;

  assign w_adv     = !r_v4 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v4;

  // --------------------------------------------------------------------------
  // Lane unpacking / packing
  // --------------------------------------------------------------------------
  logic [SFP_W-1:0] w_xr [4];
  logic [SFP_W-1:0] w_xi [4];
  logic [SFP_W-1:0] r_or4 [4];
  logic [SFP_W-1:0] r_oi4 [4];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign w_xr[k] = in_real[k*SFP_W +: SFP_W];
    assign w_xi[k] = in_imag[k*SFP_W +: SFP_W];
    assign out_real[k*SFP_W +: SFP_W] = r_or4[k];
    assign out_imag[k*SFP_W +: SFP_W] = r_oi4[k];
  end

  // --------------------------------------------------------------------------
  // Stage 1: block exponent (per pair in radix-2, global in radix-4)
  // --------------------------------------------------------------------------
  logic [EXP_W-1:0] w_max_a, w_max_b, w_max_all;
  logic [SFP_W-1:0] r_xr1 [4];
  logic [SFP_W-1:0] r_xi1 [4];
  logic [1:0]       r_mode1;
  logic [EXP_W-1:0] r_be_a1, r_be_b1;

  assign w_max_a   = f_max(f_max(f_exp(w_xr[0]), f_exp(w_xr[1])),
                           f_max(f_exp(w_xi[0]), f_exp(w_xi[1])));
  assign w_max_b   = f_max(f_max(f_exp(w_xr[2]), f_exp(w_xr[3])),
                           f_max(f_exp(w_xi[2]), f_exp(w_xi[3])));
  assign w_max_all = f_max(w_max_a, w_max_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_mode1 <= '0;
      r_be_a1 <= '0;
      r_be_b1 <= '0;
      for (int k = 0; k < 4; k++) begin
        r_xr1[k] <= '0;
        r_xi1[k] <= '0;
      end
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_mode1 <= mode;
        r_be_a1 <= mode[1] ? w_max_all : w_max_a;
        r_be_b1 <= mode[1] ? w_max_all : w_max_b;
        for (int k = 0; k < 4; k++) begin
          r_xr1[k] <= w_xr[k];
          r_xi1[k] <= w_xi[k];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: align to block exponent and apply operand sign
  // --------------------------------------------------------------------------
  logic signed [FW-1:0] r_ar2 [4];
  logic signed [FW-1:0] r_ai2 [4];
  logic [1:0]           r_mode2;
  logic [EXP_W-1:0]     r_be_a2, r_be_b2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2    <= 1'b0;
      r_mode2 <= '0;
      r_be_a2 <= '0;
      r_be_b2 <= '0;
      for (int k = 0; k < 4; k++) begin
        r_ar2[k] <= '0;
        r_ai2[k] <= '0;
      end
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_mode2 <= r_mode1;
      r_be_a2 <= r_be_a1;
      r_be_b2 <= r_be_b1;
      for (int k = 0; k < 4; k++) begin
        r_ar2[k] <= f_align(r_xr1[k], (k < 2) ? r_be_a1 : r_be_b1);
        r_ai2[k] <= f_align(r_xi1[k], (k < 2) ? r_be_a1 : r_be_b1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: butterfly sums
  // --------------------------------------------------------------------------
  logic signed [FW-1:0] w_sr [4];
  logic signed [FW-1:0] w_si [4];
  // x0 - j*x1 - x2 + j*x3 (jm) and x0 + j*x1 - x2 - j*x3 (jp)
  logic signed [FW-1:0] w_jm_r, w_jm_i, w_jp_r, w_jp_i;

  always_comb begin
    w_jm_r = r_ar2[0] + r_ai2[1] - r_ar2[2] - r_ai2[3];
    w_jm_i = r_ai2[0] - r_ar2[1] - r_ai2[2] + r_ar2[3];
    w_jp_r = r_ar2[0] - r_ai2[1] - r_ar2[2] + r_ai2[3];
    w_jp_i = r_ai2[0] + r_ar2[1] - r_ai2[2] - r_ar2[3];
    for (int k = 0; k < 4; k++) begin
      w_sr[k] = '0;
      w_si[k] = '0;
    end
    if (r_mode2[1]) begin
      w_sr[0] = r_ar2[0] + r_ar2[1] + r_ar2[2] + r_ar2[3];
      w_si[0] = r_ai2[0] + r_ai2[1] + r_ai2[2] + r_ai2[3];
      w_sr[2] = r_ar2[0] - r_ar2[1] + r_ar2[2] - r_ar2[3];
      w_si[2] = r_ai2[0] - r_ai2[1] + r_ai2[2] - r_ai2[3];
      // Inverse transform flips the sign of j, which swaps X1 and X3.
      if (r_mode2[0]) begin
        w_sr[1] = w_jp_r;
        w_si[1] = w_jp_i;
        w_sr[3] = w_jm_r;
        w_si[3] = w_jm_i;
      end else begin
        w_sr[1] = w_jm_r;
        w_si[1] = w_jm_i;
        w_sr[3] = w_jp_r;
        w_si[3] = w_jp_i;
      end
    end else begin
      w_sr[0] = r_ar2[0] + r_ar2[1];
      w_si[0] = r_ai2[0] + r_ai2[1];
      w_sr[1] = r_ar2[0] - r_ar2[1];
      w_si[1] = r_ai2[0] - r_ai2[1];
      w_sr[2] = r_ar2[2] + r_ar2[3];
      w_si[2] = r_ai2[2] + r_ai2[3];
      w_sr[3] = r_ar2[2] - r_ar2[3];
      w_si[3] = r_ai2[2] - r_ai2[3];
    end
  end

  logic signed [FW-1:0] r_sr3 [4];
  logic signed [FW-1:0] r_si3 [4];
  logic [EXP_W-1:0]     r_be_a3, r_be_b3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v3    <= 1'b0;
      r_be_a3 <= '0;
      r_be_b3 <= '0;
      for (int k = 0; k < 4; k++) begin
        r_sr3[k] <= '0;
        r_si3[k] <= '0;
      end
    end else if (w_adv) begin
      r_v3    <= r_v2;
      r_be_a3 <= r_be_a2;
      r_be_b3 <= r_be_b2;
      for (int k = 0; k < 4; k++) begin
        r_sr3[k] <= w_sr[k];
        r_si3[k] <= w_si[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 4: renormalise into the output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v4 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_or4[k] <= '0;
        r_oi4[k] <= '0;
      end
    end else if (w_adv) begin
      r_v4 <= r_v3;
      for (int k = 0; k < 4; k++) begin
        r_or4[k] <= f_renorm(r_sr3[k], (k < 2) ? r_be_a3 : r_be_b3);
        r_oi4[k] <= f_renorm(r_si3[k], (k < 2) ? r_be_a3 : r_be_b3);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Delivered-frame counter
  // --------------------------------------------------------------------------
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (r_v4 && out_ready) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sfp_dft_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfp_dft_engine
// Purpose  : Directed self-checking bench for sfp_dft_engine (default params,
//            SFP_W = 9). Expected values are hand-computed SFP encodings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfp_dft_engine;

  localparam int SFP_W = 9;
  localparam int LW    = 4 * SFP_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [LW-1:0] in_real;
  logic [LW-1:0] in_imag;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_real;
  logic [LW-1:0] out_imag;
  logic [15:0]   frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sfp_dft_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .frame_cnt (frame_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] pk(input logic [8:0] l0, input logic [8:0] l1,
                                       input logic [8:0] l2, input logic [8:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Send one frame into an empty pipeline, check latency and result, consume it.
  task automatic run_frame(input string tag, input logic [1:0] m,
                           input logic [LW-1:0] xr, input logic [LW-1:0] xi,
                           input logic [LW-1:0] er, input logic [LW-1:0] ei);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = m;
    in_real  = xr;
    in_imag  = xi;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    // Garbage after acceptance must not affect the frame in flight.
    in_valid = 1'b0;
    mode     = ~m;
    in_real  = ~xr;
    in_imag  = ~xi;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_early"}, out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_re"}, out_real, er);
    check({tag, "_im"}, out_imag, ei);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] prev_out;
    logic [8:0]    v;
    logic          prev_stall;
    logic          seen;
    int            sent;
    int            rcv;
    int            last_c;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = 2'b00;
    in_real   = '0;
    in_imag   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_imag", out_imag, 0);
    @(negedge clk);
    rst = 1'b1;

    // Radix-4 DC: four 1.0 values -> X0 = 4.0
    run_frame("r4_dc", 2'b10, pk(9'h070, 9'h070, 9'h070, 9'h070), '0,
              pk(9'h090, 9'h000, 9'h000, 9'h000), '0);
    // Dual radix-2: (1,1) and (-1,-1)
    run_frame("r2_pair", 2'b00, pk(9'h070, 9'h070, 9'h170, 9'h170), '0,
              pk(9'h080, 9'h000, 9'h180, 9'h000), '0);
    // x1 = j, forward and inverse
    run_frame("r4_j_fwd", 2'b10, '0, pk(9'h000, 9'h070, 9'h000, 9'h000),
              pk(9'h000, 9'h070, 9'h000, 9'h170), pk(9'h070, 9'h000, 9'h170, 9'h000));
    run_frame("r4_j_inv", 2'b11, '0, pk(9'h000, 9'h070, 9'h000, 9'h000),
              pk(9'h000, 9'h170, 9'h000, 9'h070), pk(9'h070, 9'h000, 9'h170, 9'h000));
    // All max values: X0 overflows to saturation, other bins cancel
    run_frame("r4_sat", 2'b10, pk(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF),
              pk(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF),
              pk(9'h0FF, 9'h000, 9'h000, 9'h000), pk(9'h0FF, 9'h000, 9'h000, 9'h000));
    // x0 = 1.0, x1 = 0.5: alignment shift of one
    run_frame("r4_align", 2'b10, pk(9'h070, 9'h060, 9'h000, 9'h000), '0,
              pk(9'h078, 9'h070, 9'h060, 9'h070), pk(9'h000, 9'h160, 9'h000, 9'h060));
    // Radix-2 with bit0 set (ignored): tiny pair flushes, large pair saturates
    // negative; each pair has its own block exponent.
    run_frame("r2_flush_sat", 2'b01, pk(9'h010, 9'h018, 9'h1F0, 9'h1F0), '0,
              pk(9'h024, 9'h000, 9'h1FF, 9'h000), '0);

    check("cnt_after_directed", frame_cnt, 7);

    // Clear the counter before the back-to-back run.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Six back-to-back frames, out_ready low in cycles 5..7.
    sent       = 0;
    rcv        = 0;
    last_c     = -1;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 6) begin
        in_valid = 1'b1;
        mode     = 2'b10;
        in_real  = pk(9'h070 | 9'(sent), 9'h000, 9'h000, 9'h000);
        in_imag  = '0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) check("stall_in_ready", in_ready, 0);
      if (prev_stall) check("stall_hold", out_real, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = out_real;
      if (out_valid && out_ready) begin
        v = 9'h070 | 9'(rcv);
        check("stall_data", out_real, {v, v, v, v});
        rcv++;
        last_c = c;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_received", rcv, 6);
    check("stall_last_cycle", last_c, 12);
    @(posedge clk);
    #1;
    check("stall_frame_cnt", frame_cnt, 6);

    // Reset pulse with a frame in flight.
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 2'b10;
    in_real  = pk(9'h070, 9'h070, 9'h070, 9'h070);
    in_imag  = '0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("midrst_no_output", seen, 0);
    run_frame("post_rst", 2'b00, pk(9'h070, 9'h070, 9'h170, 9'h170), '0,
              pk(9'h080, 9'h000, 9'h180, 9'h000), '0);
    check("post_rst_cnt", frame_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
